branch_repair_unit: RTL and testbench

BRANCH_REPAIR_UNIT -- requirements
Module: branch_repair_unit

---
 rtl/branch_repair_unit.sv | 161 ++++++++++++++++
 tb/tb_branch_repair_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_repair_unit.sv
// Branch misprediction repair: restores speculative GHR / RAS pointer, redirects fetch, updates the BTB.
// Optional macro BRU_PERF_CNT_EN adds a 32-bit completed-repair counter output BRU_repairCnt_o.
module branch_repair_unit #(
  parameter int GHR_W     = 8,
  parameter int RAS_PTR_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SBA_flush_w_i,
  input  logic [31:0]                SBA_erroVAddr_w_i,
  input  logic [31:0]                SBA_corrDest_w_i,
  input  logic                       SBA_corrTake_w_i,
  input  logic [GHR_W+RAS_PTR_W-1:0] SBA_checkPoint_w_i,
  input  logic [2:0]                 SBA_repairAction_w_i,
  input  logic                       CP0_excOccur_w_i,
  input  logic                       BPU_update_w_i,
  input  logic                       BPU_predTake_w_i,
  input  logic                       BPU_rasPush_w_i,
  input  logic                       BPU_rasPop_w_i,
  input  logic                       PCG_ready_w_i,
  output logic                       BRU_redirect_w_o,
  output logic [31:0]                BRU_redirectPC_w_o,
  output logic [GHR_W-1:0]           BRU_ghr_o,
  output logic [RAS_PTR_W-1:0]       BRU_rasPtr_o,
  output logic                       BRU_btbWe_w_o,
  output logic [31:0]                BRU_btbPC_w_o,
  output logic [31:0]                BRU_btbTarget_w_o,
  output logic                       BRU_btbTake_w_o,
  output logic                       BRU_busy_w_o
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]                BRU_repairCnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    BTBWR    = 2'd2
  } state_t;

  state_t               state;
  logic [31:0]          lat_pc;
  logic [31:0]          lat_target;
  logic                 lat_take;

  logic                 flush_acc;
  logic [GHR_W-1:0]     ckpt_ghr;
  logic [RAS_PTR_W-1:0] ckpt_ptr;
  logic [GHR_W-1:0]     restore_ghr;
  logic [RAS_PTR_W-1:0] restore_ptr;
  logic [GHR_W-1:0]     spec_ghr;
  logic [RAS_PTR_W-1:0] spec_ptr;

  assign flush_acc = SBA_flush_w_i && SBA_repairAction_w_i[0];
  assign ckpt_ghr  = SBA_checkPoint_w_i[GHR_W+RAS_PTR_W-1:RAS_PTR_W];
  assign ckpt_ptr  = SBA_checkPoint_w_i[RAS_PTR_W-1:0];

  // The restored history already contains the resolved branch's true direction.
  assign restore_ghr = {ckpt_ghr[GHR_W-2:0], SBA_corrTake_w_i};
  assign restore_ptr = SBA_repairAction_w_i[1] ? ckpt_ptr + RAS_PTR_W'(1) :
                       SBA_repairAction_w_i[2] ? ckpt_ptr - RAS_PTR_W'(1) :
                                                 ckpt_ptr;

  assign spec_ghr = BPU_update_w_i ? {BRU_ghr_o[GHR_W-2:0], BPU_predTake_w_i} : BRU_ghr_o;
  assign spec_ptr = (BPU_rasPush_w_i && !BPU_rasPop_w_i) ? BRU_rasPtr_o + RAS_PTR_W'(1) :
                    (BPU_rasPop_w_i && !BPU_rasPush_w_i) ? BRU_rasPtr_o - RAS_PTR_W'(1) :
                                                           BRU_rasPtr_o;

  assign BRU_busy_w_o = (state != IDLE);

  // NOTE: every register below uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      lat_pc             <= '0;
      lat_target         <= '0;
      lat_take           <= 1'b0;
      BRU_ghr_o          <= '0;
      BRU_rasPtr_o       <= '0;
      BRU_redirect_w_o   <= 1'b0;
      BRU_redirectPC_w_o <= '0;
      BRU_btbWe_w_o      <= 1'b0;
      BRU_btbPC_w_o      <= '0;
      BRU_btbTarget_w_o  <= '0;
      BRU_btbTake_w_o    <= 1'b0;
    end else if (CP0_excOccur_w_i) begin
      // Exception flush abandons the repair; speculative history is left alone.
      state              <= IDLE;
      lat_pc             <= '0;
      lat_target         <= '0;
      lat_take           <= 1'b0;
      BRU_redirect_w_o   <= 1'b0;
      BRU_redirectPC_w_o <= '0;
      BRU_btbWe_w_o      <= 1'b0;
      BRU_btbPC_w_o      <= '0;
      BRU_btbTarget_w_o  <= '0;
      BRU_btbTake_w_o    <= 1'b0;
    end else if (flush_acc) begin
      // A newer misprediction simply replaces whatever was in flight.
      state              <= REDIRECT;
      lat_pc             <= SBA_erroVAddr_w_i;
      lat_target         <= SBA_corrDest_w_i;
      lat_take           <= SBA_corrTake_w_i;
      BRU_ghr_o          <= restore_ghr;
      BRU_rasPtr_o       <= restore_ptr;
      BRU_redirect_w_o   <= 1'b1;
      BRU_redirectPC_w_o <= SBA_corrDest_w_i;
      BRU_btbWe_w_o      <= 1'b0;
      BRU_btbPC_w_o      <= '0;
      BRU_btbTarget_w_o  <= '0;
      BRU_btbTake_w_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          BRU_ghr_o    <= spec_ghr;
          BRU_rasPtr_o <= spec_ptr;
        end
        REDIRECT: begin
          // Predictions made while the redirect is pending come from the wrong path.
          if (PCG_ready_w_i) begin
            state              <= BTBWR;
            BRU_redirect_w_o   <= 1'b0;
            BRU_redirectPC_w_o <= '0;
            BRU_btbWe_w_o      <= 1'b1;
            BRU_btbPC_w_o      <= lat_pc;
            BRU_btbTarget_w_o  <= lat_target;
            BRU_btbTake_w_o    <= lat_take;
          end
        end
        BTBWR: begin
          state             <= IDLE;
          lat_pc            <= '0;
          lat_target        <= '0;
          lat_take          <= 1'b0;
          BRU_btbWe_w_o     <= 1'b0;
          BRU_btbPC_w_o     <= '0;
          BRU_btbTarget_w_o <= '0;
          BRU_btbTake_w_o   <= 1'b0;
        end
        default: begin
          state              <= IDLE;
          BRU_redirect_w_o   <= 1'b0;
          BRU_redirectPC_w_o <= '0;
          BRU_btbWe_w_o      <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BRU_repairCnt_o <= '0;
    end else if (state == BTBWR) begin
      BRU_repairCnt_o <= BRU_repairCnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_repair_unit.sv
// Directed self-checking bench for branch_repair_unit; counter checks are active when BRU_PERF_CNT_EN is defined.
module tb_branch_repair_unit;

  localparam int GHR_W     = 8;
  localparam int RAS_PTR_W = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       SBA_flush_w_i;
  logic [31:0]                SBA_erroVAddr_w_i;
  logic [31:0]                SBA_corrDest_w_i;
  logic                       SBA_corrTake_w_i;
  logic [GHR_W+RAS_PTR_W-1:0] SBA_checkPoint_w_i;
  logic [2:0]                 SBA_repairAction_w_i;
  logic                       CP0_excOccur_w_i;
  logic                       BPU_update_w_i;
  logic                       BPU_predTake_w_i;
  logic                       BPU_rasPush_w_i;
  logic                       BPU_rasPop_w_i;
  logic                       PCG_ready_w_i;
  logic                       BRU_redirect_w_o;
  logic [31:0]                BRU_redirectPC_w_o;
  logic [GHR_W-1:0]           BRU_ghr_o;
  logic [RAS_PTR_W-1:0]       BRU_rasPtr_o;
  logic                       BRU_btbWe_w_o;
  logic [31:0]                BRU_btbPC_w_o;
  logic [31:0]                BRU_btbTarget_w_o;
  logic                       BRU_btbTake_w_o;
  logic                       BRU_busy_w_o;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]                BRU_repairCnt_o;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;
  int we_pulses;

  branch_repair_unit #(.GHR_W(GHR_W), .RAS_PTR_W(RAS_PTR_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .SBA_flush_w_i        (SBA_flush_w_i),
    .SBA_erroVAddr_w_i    (SBA_erroVAddr_w_i),
    .SBA_corrDest_w_i     (SBA_corrDest_w_i),
    .SBA_corrTake_w_i     (SBA_corrTake_w_i),
    .SBA_checkPoint_w_i   (SBA_checkPoint_w_i),
    .SBA_repairAction_w_i (SBA_repairAction_w_i),
    .CP0_excOccur_w_i     (CP0_excOccur_w_i),
    .BPU_update_w_i       (BPU_update_w_i),
    .BPU_predTake_w_i     (BPU_predTake_w_i),
    .BPU_rasPush_w_i      (BPU_rasPush_w_i),
    .BPU_rasPop_w_i       (BPU_rasPop_w_i),
    .PCG_ready_w_i        (PCG_ready_w_i),
    .BRU_redirect_w_o     (BRU_redirect_w_o),
    .BRU_redirectPC_w_o   (BRU_redirectPC_w_o),
    .BRU_ghr_o            (BRU_ghr_o),
    .BRU_rasPtr_o         (BRU_rasPtr_o),
    .BRU_btbWe_w_o        (BRU_btbWe_w_o),
    .BRU_btbPC_w_o        (BRU_btbPC_w_o),
    .BRU_btbTarget_w_o    (BRU_btbTarget_w_o),
    .BRU_btbTake_w_o      (BRU_btbTake_w_o),
    .BRU_busy_w_o         (BRU_busy_w_o)
`ifdef BRU_PERF_CNT_EN
    ,
    .BRU_repairCnt_o      (BRU_repairCnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input logic [31:0] pc, input logic [31:0] tgt, input logic take,
                       input logic [2:0] act, input logic [7:0] g, input logic [2:0] p);
    SBA_flush_w_i        = 1'b1;
    SBA_erroVAddr_w_i    = pc;
    SBA_corrDest_w_i     = tgt;
    SBA_corrTake_w_i     = take;
    SBA_repairAction_w_i = act;
    SBA_checkPoint_w_i   = {g, p};
  endtask

  task automatic no_flush();
    SBA_flush_w_i        = 1'b0;
    SBA_repairAction_w_i = 3'b000;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_redirect"}, 32'(BRU_redirect_w_o), 32'd0);
    check({tag, "_rpc"}, BRU_redirectPC_w_o, 32'd0);
    check({tag, "_btbwe"}, 32'(BRU_btbWe_w_o), 32'd0);
    check({tag, "_busy"}, 32'(BRU_busy_w_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    no_flush();
    SBA_erroVAddr_w_i  = '0;
    SBA_corrDest_w_i   = '0;
    SBA_corrTake_w_i   = 1'b0;
    SBA_checkPoint_w_i = '0;
    CP0_excOccur_w_i   = 1'b0;
    BPU_update_w_i     = 1'b0;
    BPU_predTake_w_i   = 1'b0;
    BPU_rasPush_w_i    = 1'b0;
    BPU_rasPop_w_i     = 1'b0;
    PCG_ready_w_i      = 1'b0;
    #1;
    check_idle_zero("reset");
    check("reset_ghr", 32'(BRU_ghr_o), 32'd0);
    check("reset_ptr", 32'(BRU_rasPtr_o), 32'd0);
    check("reset_btbpc", BRU_btbPC_w_o, 32'd0);
    #10 rst = 1'b1;
    tick();

    // Speculative updates while idle.
    BPU_update_w_i = 1'b1; BPU_predTake_w_i = 1'b1; BPU_rasPush_w_i = 1'b1; tick();
    check("bpu_ghr1", 32'(BRU_ghr_o), 32'h01);
    check("bpu_ptr1", 32'(BRU_rasPtr_o), 32'd1);
    BPU_predTake_w_i = 1'b0; BPU_rasPop_w_i = 1'b1; tick();
    check("bpu_ghr2", 32'(BRU_ghr_o), 32'h02);
    check("bpu_pushpop", 32'(BRU_rasPtr_o), 32'd1);
    BPU_predTake_w_i = 1'b1; BPU_rasPush_w_i = 1'b0; tick();
    check("bpu_ghr3", 32'(BRU_ghr_o), 32'h05);
    check("bpu_pop", 32'(BRU_rasPtr_o), 32'd0);
    BPU_update_w_i = 1'b0; tick();
    check("bpu_pop_wrap", 32'(BRU_rasPtr_o), 32'd7);
    check("bpu_ghr_hold", 32'(BRU_ghr_o), 32'h05);
    BPU_rasPop_w_i = 1'b0; BPU_rasPush_w_i = 1'b1; tick();
    check("bpu_push_wrap", 32'(BRU_rasPtr_o), 32'd0);
    BPU_rasPush_w_i = 1'b0;

    // Basic repair with ready already high; a same-cycle BPU update is discarded.
    flush(32'h9000_0040, 32'hBFC0_0100, 1'b1, 3'b001, 8'hA5, 3'd3);
    PCG_ready_w_i = 1'b1; BPU_update_w_i = 1'b1; BPU_predTake_w_i = 1'b0; BPU_rasPush_w_i = 1'b1;
    tick();
    no_flush(); BPU_update_w_i = 1'b0; BPU_rasPush_w_i = 1'b0;
    check("basic_ghr", 32'(BRU_ghr_o), 32'h4B);
    check("basic_ptr", 32'(BRU_rasPtr_o), 32'd3);
    check("basic_redirect", 32'(BRU_redirect_w_o), 32'd1);
    check("basic_rpc", BRU_redirectPC_w_o, 32'hBFC0_0100);
    check("basic_we0", 32'(BRU_btbWe_w_o), 32'd0);
    check("basic_busy", 32'(BRU_busy_w_o), 32'd1);
    tick();
    check("basic_we", 32'(BRU_btbWe_w_o), 32'd1);
    check("basic_btbpc", BRU_btbPC_w_o, 32'h9000_0040);
    check("basic_btbtgt", BRU_btbTarget_w_o, 32'hBFC0_0100);
    check("basic_btbtake", 32'(BRU_btbTake_w_o), 32'd1);
    check("basic_redir_off", 32'(BRU_redirect_w_o), 32'd0);
    tick();
    check_idle_zero("basic_end");

    // Redirect held while the fetch generator stalls.
    PCG_ready_w_i = 1'b0;
    flush(32'h8000_0100, 32'h8000_0200, 1'b0, 3'b001, 8'h00, 3'd5);
    tick();
    no_flush();
    check("stall_ghr", 32'(BRU_ghr_o), 32'h00);
    check("stall_ptr", 32'(BRU_rasPtr_o), 32'd5);
    we_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_redirect", 32'(BRU_redirect_w_o), 32'd1);
      check("stall_rpc", BRU_redirectPC_w_o, 32'h8000_0200);
      check("stall_we", 32'(BRU_btbWe_w_o), 32'd0);
      tick();
    end
    PCG_ready_w_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (BRU_btbWe_w_o === 1'b1) begin
        we_pulses++;
        check("stall_btbtake", 32'(BRU_btbTake_w_o), 32'd0);
        check("stall_btbpc", BRU_btbPC_w_o, 32'h8000_0100);
      end
    end
    check("stall_we_pulses", 32'(we_pulses), 32'd1);
    check_idle_zero("stall_end");

    // RAS pointer wrap on call and return repairs.
    flush(32'h8000_0300, 32'h8000_0304, 1'b0, 3'b011, 8'hFF, 3'd7);
    tick();
    no_flush();
    check("call_ptr", 32'(BRU_rasPtr_o), 32'd0);
    check("call_ghr", 32'(BRU_ghr_o), 32'hFE);
    tick(); tick();
    flush(32'h8000_0308, 32'h8000_030C, 1'b1, 3'b101, 8'h01, 3'd0);
    tick();
    no_flush();
    check("ret_ptr", 32'(BRU_rasPtr_o), 32'd7);
    check("ret_ghr", 32'(BRU_ghr_o), 32'h03);
    tick(); tick();

    // Flush without the need-repair bit is ignored.
    flush(32'h8000_0500, 32'h8000_0504, 1'b1, 3'b110, 8'h77, 3'd1);
    tick();
    no_flush();
    check("norepair_busy", 32'(BRU_busy_w_o), 32'd0);
    check("norepair_ghr", 32'(BRU_ghr_o), 32'h03);

    // Exception during REDIRECT beats a same-cycle flush and BPU update.
    PCG_ready_w_i = 1'b0;
    flush(32'h8000_0380, 32'h8000_0400, 1'b1, 3'b001, 8'h3C, 3'd2);
    tick();
    check("exc_pre_ghr", 32'(BRU_ghr_o), 32'h79);
    check("exc_pre_redirect", 32'(BRU_redirect_w_o), 32'd1);
    flush(32'h1234_0000, 32'h1234_5678, 1'b0, 3'b011, 8'h00, 3'd0);
    CP0_excOccur_w_i = 1'b1; BPU_update_w_i = 1'b1; BPU_rasPop_w_i = 1'b1;
    tick();
    no_flush(); CP0_excOccur_w_i = 1'b0; BPU_update_w_i = 1'b0; BPU_rasPop_w_i = 1'b0;
    check_idle_zero("exc");
    check("exc_ghr", 32'(BRU_ghr_o), 32'h79);
    check("exc_ptr", 32'(BRU_rasPtr_o), 32'd2);
    PCG_ready_w_i = 1'b1;
    we_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (BRU_btbWe_w_o === 1'b1) we_pulses++;
    end
    check("exc_no_btbwe", 32'(we_pulses), 32'd0);

    // Second flush while redirecting: latest wins, one BTB write.
    PCG_ready_w_i = 1'b0;
    flush(32'h8000_0A00, 32'h8000_0800, 1'b0, 3'b001, 8'h10, 3'd1);
    tick();
    check("second_ghr1", 32'(BRU_ghr_o), 32'h20);
    flush(32'h8000_0F00, 32'h8000_1000, 1'b1, 3'b001, 8'h10, 3'd1);
    tick();
    no_flush();
    check("second_rpc", BRU_redirectPC_w_o, 32'h8000_1000);
    check("second_ghr2", 32'(BRU_ghr_o), 32'h21);
    check("second_redirect", 32'(BRU_redirect_w_o), 32'd1);
    PCG_ready_w_i = 1'b1;
    we_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (BRU_btbWe_w_o === 1'b1) begin
        we_pulses++;
        check("second_btbpc", BRU_btbPC_w_o, 32'h8000_0F00);
        check("second_btbtgt", BRU_btbTarget_w_o, 32'h8000_1000);
      end
    end
    check("second_we_pulses", 32'(we_pulses), 32'd1);

    // Asynchronous reset in the middle of a redirect.
    PCG_ready_w_i = 1'b0;
    flush(32'h8000_0C00, 32'h8000_0C40, 1'b1, 3'b011, 8'hC3, 3'd4);
    tick();
    no_flush();
    check("rst_pre_redirect", 32'(BRU_redirect_w_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_idle_zero("async_rst");
    check("async_rst_ghr", 32'(BRU_ghr_o), 32'd0);
    check("async_rst_ptr", 32'(BRU_rasPtr_o), 32'd0);
`ifdef BRU_PERF_CNT_EN
    check("async_rst_cnt", BRU_repairCnt_o, 32'd0);
`endif
    #2 rst = 1'b1;
    tick();

    // First repair after reset behaves like any other; two full repairs.
    PCG_ready_w_i = 1'b1;
    for (int r = 0; r < 2; r++) begin
      flush(32'h9000_0040, 32'hBFC0_0100, 1'b1, 3'b001, 8'hA5, 3'd3);
      tick();
      no_flush();
      check("post_rst_ghr", 32'(BRU_ghr_o), 32'h4B);
      check("post_rst_rpc", BRU_redirectPC_w_o, 32'hBFC0_0100);
      tick();
      check("post_rst_we", 32'(BRU_btbWe_w_o), 32'd1);
      tick();
      check("post_rst_idle", 32'(BRU_busy_w_o), 32'd0);
    end
`ifdef BRU_PERF_CNT_EN
    check("perf_cnt", BRU_repairCnt_o, 32'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
